pipo_share_arbiter: RTL
=======================

Name: pipo_share_arbiter

Overview:
- Round-robin arbiter and load sequencer for one shared parallel-in parallel-out register.
- N requesters each present a word and a request. The block grants one requester, loads that word into the shared register, and holds the grant for a fixed window. It then releases and re-arbitrates.
- Sits in front of the shared PIPO register and owns its load enable.

Parameters:
N, 4, number of requesters (>=2)
W, 4, data width of the shared register
HOLD, 2, cycles the grant is held after load (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
req  input  N  request per requester, level
req_data  input  N*W  requester i word at bits [i*W +: W]
gnt  output  N  one-hot grant, registered
load  output  1  one-cycle pulse, coincident with the register update
q  output  W  shared register contents
q_valid  output  1  q holds data loaded since reset
owner  output  clog2(N)  index of last granted requester
busy  output  1  high while in HOLD state

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - Outputs: gnt=0, load=0, q=0, q_valid=0, owner=0, busy=0.
  - Internal: state=IDLE, round-robin pointer ptr=0, hold counter=0.
- Release is synchronous: first rising edge with rst=1 evaluates IDLE normally.
- States: IDLE, HOLD.
- IDLE, req==0: outputs unchanged, gnt=0, load=0.
- IDLE, req!=0, at the edge:
  - Winner w = first set bit of req scanning ptr, ptr+1, ... with wrap modulo N.
  - Registered updates: gnt=onehot(w), owner=w, q=req_data[w], load=1, q_valid=1, busy=1.
  - Counter=HOLD-1; state -> HOLD.
  - Latency: req sampled at edge k; gnt, q and load are visible after edge k.
- HOLD:
  - load=0 after its single cycle.
  - gnt, owner and q are frozen; req and req_data changes are ignored.
  - Counter decrements each edge. gnt is asserted for exactly HOLD cycles.
- HOLD exit: on the edge where counter==0:
  - gnt=0, busy=0, state -> IDLE, ptr=(w+1) mod N.
  - q, q_valid and owner retain their values.
- Mandatory gap: one IDLE cycle between grants. Grant-to-grant period = HOLD+1 cycles under continuous requests.
- Withdrawal during HOLD: no abort. The grant runs to completion and the pointer still advances past w.
- Fairness: a continuously requesting requester waits at most (N-1)*(HOLD+1) cycles after the current grant ends.
- Reset mid-HOLD: immediate clear to reset values. No partial release behaviour and no load pulse.
- Invariants:
  - gnt is always zero or one-hot.
  - load is high only on the first cycle of a grant.
  - busy == (gnt != 0).
- All outputs are registered. There is no combinational path from req to gnt.

Test Plan:
All scenarios use N=4, W=4, HOLD=2.
- Reset hold and release: rst=0, req=4'b1111, data0=4'b1101 -> gnt=0, q=0, q_valid=0, load=0. On the first edge after rst=1 -> gnt=0001, q=1101, load=1 for 1 cycle, owner=0.
- Single requester: req=4'b0100 held, data2=4'b1101 -> gnt=0100 for 2 cycles, then gnt=0 for 1 cycle, then 0100 again. q=1101, owner=2, one load pulse per grant.
- Round robin: req=4'b1111 continuously -> grant sequence 0001, 0010, 0100, 1000, 0001, each grant 2 cycles wide with a 1-cycle gap (period 3). q follows each requester's word.
- Data freeze: during req2's HOLD, data2 changes 4'b1101 -> 4'b1000 -> q stays 1101 through HOLD. Next grant to 2 loads 1000.
- Async reset mid-HOLD: rst driven 0 between clock edges while gnt=0010 -> gnt, q, q_valid, busy go to 0 immediately. After release with req=4'b1111 -> first grant is 0001 (ptr reset to 0).
- Withdrawal: req1 drops one cycle after gnt=0010 -> gnt=0010 still lasts 2 cycles. With req=4'b1001 the next grant is 1000, not 0001.

Source files
------------

// File: rtl/pipo_share_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipo_share_arbiter: round-robin grant and load sequencer for a shared  |
// | PIPO register; grant is held HOLD cycles, then one idle gap.           |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pipo_share_arbiter #(
    parameter int N    = 4,
    parameter int W    = 4,
    parameter int HOLD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         gnt,
    output logic                 load,
    output logic [W-1:0]         q,
    output logic                 q_valid,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          load_q, load_d;
    logic [W-1:0]  q_q, q_d;
    logic          q_valid_q, q_valid_d;
    logic [IW-1:0] owner_q, owner_d;
    logic          busy_q, busy_d;

    logic          win_found;
    logic [IW-1:0] win_idx;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr_q) + k) % N]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        load_d    = 1'b0;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d   = ST_HOLD;
                    gnt_d     = N'(1) << win_idx;
                    owner_d   = win_idx;
                    q_d       = req_data[int'(win_idx)*W +: W];
                    load_d    = 1'b1;
                    q_valid_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = CW'(HOLD - 1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            load_q    <= 1'b0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            owner_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            load_q    <= load_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            owner_q   <= owner_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign load    = load_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign owner   = owner_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire
